// File: rtl/maxpool_stream_pkg.sv
// maxpool_stream_pkg: shared FSM encoding and packed filter-vector helpers for the pooling stage
package maxpool_stream_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   function automatic int vec_width(input int num_filters, input int data_width);
      return num_filters * data_width;
   endfunction

   function automatic int slice_lsb(input int filter, input int data_width);
      return filter * data_width;
   endfunction

endpackage

// File: rtl/maxpool_stream_max2.sv
// maxpool_stream_max2: per-sample two-input maximum, signed or unsigned compare
module maxpool_stream_max2
   import maxpool_stream_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SIGNED_DATA = 1
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] max_o
);

   logic a_gt;

   // Pick the larger operand; ties return b, which equals a anyway
   always_comb begin
      a_gt  = (SIGNED_DATA != 0) ? ($signed(a_i) > $signed(b_i)) : (a_i > b_i);
      max_o = a_gt ? a_i : b_i;
   end

endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 stride-2 max-pool over raster conv output; POOL_RELU_EN clamps negatives to 0
module maxpool_stream
   import maxpool_stream_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_FILTERS = 3,
   parameter int FMAP_WIDTH  = 32,
   parameter int FMAP_HEIGHT = 32,
   parameter int SIGNED_DATA = 1
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [vec_width(NUM_FILTERS, DATA_WIDTH)-1:0]     conv_in,
   input  logic                                              conv_valid,
   input  logic                                              frame_start,
   output logic [vec_width(NUM_FILTERS, DATA_WIDTH)-1:0]     pool_out,
   output logic                                              pool_valid,
   output logic                                              frame_done
);

   localparam int VW   = vec_width(NUM_FILTERS, DATA_WIDTH);
   localparam int CW   = (FMAP_WIDTH > 2) ? $clog2(FMAP_WIDTH) : 1;
   localparam int RW   = (FMAP_HEIGHT > 2) ? $clog2(FMAP_HEIGHT) : 1;
   localparam int LB_D = (FMAP_WIDTH / 2 > 0) ? FMAP_WIDTH / 2 : 1;
   localparam int IW   = (LB_D > 2) ? $clog2(LB_D) : 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    col_q, col_d, col_c;
   logic [RW-1:0]    row_q, row_d, row_c;
   logic             run, accept, col_end, last, emit;
   logic [IW-1:0]    lb_idx;
   logic [VW-1:0]    hold_q, hmax, vmax, pooled, lb_rd;
   logic [VW-1:0]    pool_out_q, pool_out_d;
   logic             pool_valid_q, frame_done_q;
   logic [VW-1:0]    lb_q [LB_D];

   // frame_start forces RUN and position (0,0) for this very cycle's sample
   always_comb begin
      run        = frame_start || state_q == RUN;
      col_c      = frame_start ? '0 : col_q;
      row_c      = frame_start ? '0 : row_q;
      accept     = conv_valid && run;
      col_end    = col_c == CW'(FMAP_WIDTH - 1);
      last       = accept && col_end && row_c == RW'(FMAP_HEIGHT - 1);
      emit       = accept && col_c[0] && row_c[0];
      lb_idx     = IW'(col_c >> 1);
      lb_rd      = lb_q[lb_idx];
      state_d    = last ? IDLE : (run ? RUN : IDLE);
      col_d      = accept ? (col_end ? '0 : col_c + 1'b1) : col_c;
      row_d      = (accept && col_end) ? (last ? '0 : row_c + 1'b1) : row_c;
      pool_out_d = emit ? pooled : pool_out_q;
   end

   for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filt
      maxpool_stream_max2 #(.DATA_WIDTH(DATA_WIDTH), .SIGNED_DATA(SIGNED_DATA)) u_hmax (
         .a_i   (hold_q[f*DATA_WIDTH +: DATA_WIDTH]),
         .b_i   (conv_in[f*DATA_WIDTH +: DATA_WIDTH]),
         .max_o (hmax[f*DATA_WIDTH +: DATA_WIDTH])
      );
      maxpool_stream_max2 #(.DATA_WIDTH(DATA_WIDTH), .SIGNED_DATA(SIGNED_DATA)) u_vmax (
         .a_i   (lb_rd[f*DATA_WIDTH +: DATA_WIDTH]),
         .b_i   (hmax[f*DATA_WIDTH +: DATA_WIDTH]),
         .max_o (vmax[f*DATA_WIDTH +: DATA_WIDTH])
      );
`ifdef POOL_RELU_EN
      assign pooled[f*DATA_WIDTH +: DATA_WIDTH] =
         (SIGNED_DATA != 0 && vmax[(f+1)*DATA_WIDTH-1]) ? '0 : vmax[f*DATA_WIDTH +: DATA_WIDTH];
`else
      assign pooled[f*DATA_WIDTH +: DATA_WIDTH] = vmax[f*DATA_WIDTH +: DATA_WIDTH];
`endif
   end

   // Datapath storage: even-column hold and even-row half-width line buffer, contents need no reset
   always_ff @(posedge clk) begin
      if (accept && !col_c[0]) hold_q <= conv_in;
      if (accept && col_c[0] && !row_c[0]) lb_q[lb_idx] <= hmax;
   end

   // FSM, raster counters and registered output strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         pool_out_q   <= '0;
         pool_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pool_out_q   <= pool_out_d;
         pool_valid_q <= emit;
         frame_done_q <= last;
      end
   end

   assign pool_out   = pool_out_q;
   assign pool_valid = pool_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: scoreboard bench for maxpool_stream on a 4x4 signed 2-filter map and a 5x3 unsigned 1-filter map
module tb_maxpool_stream;

   typedef struct {logic [15:0] v; int c;} exp_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] in_m = '0;
   logic        v_m = 1'b0, fs_m = 1'b0;
   logic [15:0] out_m;
   logic        pv_m, fd_m;
   logic [7:0]  in_o = '0;
   logic        v_o = 1'b0, fs_o = 1'b0;
   logic [7:0]  out_o;
   logic        pv_o, fd_o;

   int cyc = 0, n_chk = 0, n_err = 0;
   exp_t q_pool [2][$];
   int   q_fd   [2][$];
   logic [15:0] last_out [2] = '{16'h0, 16'h0};
   int wd [2] = '{4, 5};
   int ht [2] = '{4, 3};
   int nf [2] = '{2, 1};
   bit sg [2] = '{1'b1, 1'b0};
   bit active [2] = '{1'b0, 1'b0};
   int idx [2] = '{0, 0};
   int fr [2][16][2];
   logic [15:0] po [2];
   logic        pv [2], fd [2];

   maxpool_stream #(.DATA_WIDTH(8), .NUM_FILTERS(2), .FMAP_WIDTH(4), .FMAP_HEIGHT(4), .SIGNED_DATA(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .conv_in(in_m), .conv_valid(v_m), .frame_start(fs_m),
      .pool_out(out_m), .pool_valid(pv_m), .frame_done(fd_m)
   );

   maxpool_stream #(.DATA_WIDTH(8), .NUM_FILTERS(1), .FMAP_WIDTH(5), .FMAP_HEIGHT(3), .SIGNED_DATA(0)) u_odd (
      .clk(clk), .rst_n(rst_n), .conv_in(in_o), .conv_valid(v_o), .frame_start(fs_o),
      .pool_out(out_o), .pool_valid(pv_o), .frame_done(fd_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      po[0] = out_m;
      po[1] = {8'h00, out_o};
      pv[0] = pv_m;
      pv[1] = pv_o;
      fd[0] = fd_m;
      fd[1] = fd_o;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Pops expected vectors as the DUTs produce them; checks value, timing and hold behaviour
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (pv[d]) begin
               if (q_pool[d].size() == 0) check($sformatf("spurious_pool%0d", d), 32'd1, 32'd0);
               else begin
                  automatic exp_t e;
                  e = q_pool[d].pop_front();
                  check($sformatf("pool_val%0d", d), {16'h0, po[d]}, {16'h0, e.v});
                  check($sformatf("pool_cyc%0d", d), cyc, e.c);
                  last_out[d] = e.v;
               end
            end else check($sformatf("pool_hold%0d", d), {16'h0, po[d]}, {16'h0, last_out[d]});
            if (fd[d]) begin
               if (q_fd[d].size() == 0) check($sformatf("spurious_done%0d", d), 32'd1, 32'd0);
               else check($sformatf("done_cyc%0d", d), cyc, q_fd[d].pop_front());
            end
         end
      end
   end

   task automatic step(input int d, input bit fs, input bit v, input logic [15:0] x);
      int r, c, p, m, s;
      exp_t e;
      @(negedge clk);
      fs_m = (d == 0) && fs;
      v_m  = (d == 0) && v;
      in_m = x;
      fs_o = (d == 1) && fs;
      v_o  = (d == 1) && v;
      in_o = x[7:0];
      if (fs) begin
         active[d] = 1'b1;
         idx[d] = 0;
      end
      if (v && active[d]) begin
         p = idx[d];
         r = p / wd[d];
         c = p % wd[d];
         for (int f = 0; f < nf[d]; f++)
            fr[d][p][f] = sg[d] ? int'($signed(x[f*8 +: 8])) : int'(x[f*8 +: 8]);
         if (r % 2 == 1 && c % 2 == 1) begin
            e.v = '0;
            for (int f = 0; f < nf[d]; f++) begin
               m = fr[d][p][f];
               s = fr[d][p-1][f];
               if (s > m) m = s;
               s = fr[d][p-wd[d]][f];
               if (s > m) m = s;
               s = fr[d][p-wd[d]-1][f];
               if (s > m) m = s;
`ifdef POOL_RELU_EN
               if (m < 0) m = 0;
`endif
               e.v[f*8 +: 8] = m[7:0];
            end
            e.c = cyc + 1;
            q_pool[d].push_back(e);
         end
         if (p == wd[d] * ht[d] - 1) begin
            active[d] = 1'b0;
            idx[d] = 0;
            q_fd[d].push_back(cyc + 1);
         end else idx[d] = p + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      logic [15:0] blk [16];
      repeat (3) @(negedge clk);
      check("rst_pv_m", {31'h0, pv_m}, 32'd0);
      check("rst_out_m", {16'h0, out_m}, 32'd0);
      check("rst_fd_m", {31'h0, fd_m}, 32'd0);
      check("rst_pv_o", {31'h0, pv_o}, 32'd0);
      check("rst_out_o", {24'h0, out_o}, 32'd0);
      rst_n = 1'b1;
      idle(2);
      // raster 0..15 on f0, mixed-sign pattern on f1, frame_start alone first
      step(0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, {8'(i * 37 + 3), 8'(i)});
      idle(3);
      // valid in IDLE without frame_start is ignored
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 16'h7f7f);
      idle(2);
      // same frame, frame_start coincident with pixel 0, valid toggling
      for (int i = 0; i < 16; i++) begin
         step(0, i == 0, 1'b1, {8'(i * 37 + 3), 8'(i)});
         step(0, 1'b0, 1'b0, 16'h7f7f);
      end
      idle(3);
      // signed block with tie-free negatives and full-range extremes
      for (int i = 0; i < 16; i++) blk[i] = {8'(i * 53), 8'(i * 11 - 60)};
      blk[0] = {8'sd127, -8'sd5};
      blk[1] = {-8'sd128, -8'sd3};
      blk[4] = {8'sd0, -8'sd8};
      blk[5] = {8'sd1, -8'sd1};
      blk[10] = {8'h40, 8'h40};
      blk[11] = {8'h40, 8'h40};
      for (int i = 0; i < 16; i++) step(0, i == 0, 1'b1, blk[i]);
      idle(3);
      // restart after 6 samples, then a clean frame with different data
      for (int i = 0; i < 6; i++) step(0, i == 0, 1'b1, {8'(200 - i), 8'(90 + i)});
      for (int i = 0; i < 16; i++) step(0, i == 0, 1'b1, {8'(i * 7), 8'(250 - i * 3)});
      idle(3);
      // 5x3 unsigned map: trailing column and row consumed, never emitted
      for (int i = 0; i < 15; i++) step(1, i == 0, 1'b1, {8'h0, 8'(i * 17)});
      step(1, 1'b0, 1'b0, 16'h0);
      idle(3);
      // asynchronous reset mid-frame clears outputs immediately
      for (int i = 0; i < 8; i++) step(0, i == 0, 1'b1, {8'(i + 1), 8'(i + 20)});
      idle(2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      last_out[0] = '0;
      last_out[1] = '0;
      active[0] = 1'b0;
      idx[0] = 0;
      #1;
      check("arst_pv", {31'h0, pv_m}, 32'd0);
      check("arst_out", {16'h0, out_m}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 16'h5555);
      for (int i = 0; i < 16; i++) step(0, i == 0, 1'b1, {8'(i * 29), 8'(15 - i)});
      idle(4);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("leftover_pool%0d", d), q_pool[d].size(), 32'd0);
         check($sformatf("leftover_done%0d", d), q_fd[d].size(), 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
